// File: rtl/ss_map_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ss_map_sequencer: steps the world-map index on screen-edge crossings,      |
// | runs the teleport handshake and blanks video while a transition is active. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ss_map_sequencer #(
  parameter int         NUM_MAPS     = 3,
  parameter logic [7:0] RIGHT_EDGE   = 8'h7C,
  parameter logic [7:0] LEFT_EDGE    = 8'h01,
  parameter logic [7:0] ENTRY_LEFT   = 8'h02,
  parameter logic [7:0] ENTRY_RIGHT  = 8'h7B,
  parameter int         BLANK_CYCLES = 16,
  parameter int         ACK_TIMEOUT  = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] LocX,
  input  logic       warp_ack,
  output logic [1:0] map_sel,
  output logic       warp_req,
  output logic [7:0] warp_x,
  output logic       blank,
  output logic       level_done
);

  localparam int TIMER_W = (ACK_TIMEOUT  > 1) ? $clog2(ACK_TIMEOUT)  : 1;
  localparam int COUNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [1:0]         LAST_MAP   = 2'(NUM_MAPS - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 1);
  localparam logic [COUNT_W-1:0] COUNT_INIT = COUNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_WARP  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t             r_state, w_state_n;
  logic               r_armed, w_armed_n;
  logic [1:0]         r_pending, w_pending_n;
  logic [TIMER_W-1:0] r_timer, w_timer_n;
  logic [COUNT_W-1:0] r_count, w_count_n;
  logic [1:0]         r_map_sel, w_map_sel_n;
  logic               r_warp_req, w_warp_req_n;
  logic [7:0]         r_warp_x, w_warp_x_n;
  logic               r_blank, w_blank_n;
  logic               r_level_done, w_level_done_n;

  logic w_at_right, w_at_left, w_interior;

  assign w_at_right = (LocX >= RIGHT_EDGE);
  assign w_at_left  = (LocX <= LEFT_EDGE);
  assign w_interior = !w_at_right && !w_at_left;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_PLAY;
      r_armed      <= 1'b0;
      r_pending    <= 2'd0;
      r_timer      <= '0;
      r_count      <= '0;
      r_map_sel    <= 2'd0;
      r_warp_req   <= 1'b0;
      r_warp_x     <= 8'h00;
      r_blank      <= 1'b0;
      r_level_done <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_armed      <= w_armed_n;
      r_pending    <= w_pending_n;
      r_timer      <= w_timer_n;
      r_count      <= w_count_n;
      r_map_sel    <= w_map_sel_n;
      r_warp_req   <= w_warp_req_n;
      r_warp_x     <= w_warp_x_n;
      r_blank      <= w_blank_n;
      r_level_done <= w_level_done_n;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_armed_n      = r_armed;
    w_pending_n    = r_pending;
    w_timer_n      = r_timer;
    w_count_n      = r_count;
    w_map_sel_n    = r_map_sel;
    w_warp_req_n   = r_warp_req;
    w_warp_x_n     = r_warp_x;
    w_blank_n      = r_blank;
    w_level_done_n = 1'b0;

    case (r_state)
      ST_PLAY: begin
        // Re-arming needs an interior position so a player parked on an edge cannot retrigger.
        if (w_interior) begin
          w_armed_n = 1'b1;
        end
        if (enable && r_armed) begin
          if (w_at_right) begin
            if (r_map_sel < LAST_MAP) begin
              w_pending_n  = r_map_sel + 2'd1;
              w_warp_x_n   = ENTRY_LEFT;
              w_warp_req_n = 1'b1;
              w_blank_n    = 1'b1;
              w_timer_n    = '0;
              w_state_n    = ST_WARP;
            end else begin
              w_level_done_n = 1'b1;
              w_armed_n      = 1'b0;
            end
          end else if (w_at_left && (r_map_sel != 2'd0)) begin
            w_pending_n  = r_map_sel - 2'd1;
            w_warp_x_n   = ENTRY_RIGHT;
            w_warp_req_n = 1'b1;
            w_blank_n    = 1'b1;
            w_timer_n    = '0;
            w_state_n    = ST_WARP;
          end
        end
      end

      ST_WARP: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (warp_ack) begin
          w_map_sel_n  = r_pending;
          w_warp_req_n = 1'b0;
          w_count_n    = COUNT_INIT;
          w_state_n    = ST_BLANK;
        end else if (r_timer == TIMER_LAST) begin
          w_warp_req_n = 1'b0;
          w_blank_n    = 1'b0;
          w_armed_n    = 1'b0;
          w_state_n    = ST_PLAY;
        end else begin
          w_timer_n = r_timer + 1'b1;
        end
      end

      ST_BLANK: begin
        if (r_count == '0) begin
          w_blank_n = 1'b0;
          w_armed_n = 1'b0;
          w_state_n = ST_PLAY;
        end else begin
          w_count_n = r_count - 1'b1;
        end
      end

      default: begin
        w_state_n = ST_PLAY;
      end
    endcase
  end

  assign map_sel    = r_map_sel;
  assign warp_req   = r_warp_req;
  assign warp_x     = r_warp_x;
  assign blank      = r_blank;
  assign level_done = r_level_done;

endmodule
`default_nettype wire

// File: tb/tb_ss_map_sequencer.sv
`default_nettype none
// Testbench for ss_map_sequencer: directed stimulus pushes expected output
// changes into a queue; a negedge monitor compares every observed change.
module tb_ss_map_sequencer;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] LocX;
  logic       warp_ack;
  logic [1:0] map_sel;
  logic       warp_req;
  logic [7:0] warp_x;
  logic       blank;
  logic       level_done;

  ss_map_sequencer dut (
    .clk        (clk),
    .reset      (rst_n),
    .enable     (enable),
    .LocX       (LocX),
    .warp_ack   (warp_ack),
    .map_sel    (map_sel),
    .warp_req   (warp_req),
    .warp_x     (warp_x),
    .blank      (blank),
    .level_done (level_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {map_sel, warp_req, warp_x, blank, level_done}
  logic [12:0] outs;
  assign outs = {map_sel, warp_req, warp_x, blank, level_done};

  typedef struct {
    int          at;
    logic [12:0] o;
  } exp_t;

  exp_t exp_q[$];
  int passed = 0;
  int total  = 0;
  logic        mon_en = 1'b0;
  logic [12:0] mon_prev = '0;

  always @(negedge clk) begin
    if (mon_en && (outs !== mon_prev)) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_change cyc=%0d actual=%h required=no change", cyc, outs);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.o !== outs || e.at != cyc)
          $display("FAIL event actual=%h@%0d required=%h@%0d", outs, cyc, e.o, e.at);
        else
          passed++;
      end
      mon_prev = outs;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input int d, input logic [1:0] ms, input logic wr,
                           input logic [7:0] wx, input logic bl, input logic ld);
    exp_t e;
    e.at = cyc + d;
    e.o  = {ms, wr, wx, bl, ld};
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [12:0] act, input logic [12:0] req);
    total++;
    if (act !== req) $display("FAIL %s actual=%h required=%h", name, act, req);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; LocX = 8'h01; warp_ack = 1'b0;
    tick(3);
    check_now("reset_outputs", outs, 13'h0);
    rst_n = 1'b1; enable = 1'b1;
    mon_prev = outs; mon_en = 1'b1;

    // Unarmed after reset: edges do nothing
    tick(3);
    check_now("unarmed_left", outs, 13'h0);
    LocX = 8'h7C;
    tick(3);
    check_now("unarmed_right", outs, 13'h0);

    // Forward 0 -> 1, ack after 3 cycles, 16 blank cycles
    LocX = 8'h40; tick(1);
    LocX = 8'h7C; expect_ev(1, 2'd0, 1'b1, 8'h02, 1'b1, 1'b0);
    tick(1); tick(3);
    warp_ack = 1'b1;
    expect_ev(1,  2'd1, 1'b0, 8'h02, 1'b1, 1'b0);
    expect_ev(17, 2'd1, 1'b0, 8'h02, 1'b0, 1'b0);
    tick(1); warp_ack = 1'b0; LocX = 8'h40;
    tick(20);

    // Forward 1 -> 2 with immediate ack
    LocX = 8'h7C; expect_ev(1, 2'd1, 1'b1, 8'h02, 1'b1, 1'b0);
    tick(1); warp_ack = 1'b1; LocX = 8'h40;
    expect_ev(1,  2'd2, 1'b0, 8'h02, 1'b1, 1'b0);
    expect_ev(17, 2'd2, 1'b0, 8'h02, 1'b0, 1'b0);
    tick(1); warp_ack = 1'b0;
    tick(20);

    // Backward 2 -> 1; held left edge must not retrigger
    LocX = 8'h01; expect_ev(1, 2'd2, 1'b1, 8'h7B, 1'b1, 1'b0);
    tick(1); tick(2);
    warp_ack = 1'b1;
    expect_ev(1,  2'd1, 1'b0, 8'h7B, 1'b1, 1'b0);
    expect_ev(17, 2'd1, 1'b0, 8'h7B, 1'b0, 1'b0);
    tick(1); warp_ack = 1'b0;
    tick(30);

    // Back to map 2
    LocX = 8'h40; tick(2);
    LocX = 8'h7C; expect_ev(1, 2'd1, 1'b1, 8'h02, 1'b1, 1'b0);
    tick(1); warp_ack = 1'b1; LocX = 8'h40;
    expect_ev(1,  2'd2, 1'b0, 8'h02, 1'b1, 1'b0);
    expect_ev(17, 2'd2, 1'b0, 8'h02, 1'b0, 1'b0);
    tick(1); warp_ack = 1'b0;
    tick(20);

    // Right edge on last map: single level_done pulse, no repeat while held
    LocX = 8'h7E;
    expect_ev(1, 2'd2, 1'b0, 8'h02, 1'b0, 1'b1);
    expect_ev(2, 2'd2, 1'b0, 8'h02, 1'b0, 1'b0);
    tick(12);

    // Timeout: warp_req high for exactly 1024 cycles, later ack ignored
    LocX = 8'h40; tick(2);
    LocX = 8'h01;
    expect_ev(1,    2'd2, 1'b1, 8'h7B, 1'b1, 1'b0);
    expect_ev(1025, 2'd2, 1'b0, 8'h7B, 1'b0, 1'b0);
    tick(1030);
    warp_ack = 1'b1; tick(3);
    warp_ack = 1'b0; tick(3);

    // Asynchronous reset in the middle of BLANK
    LocX = 8'h40; tick(2);
    LocX = 8'h01; expect_ev(1, 2'd2, 1'b1, 8'h7B, 1'b1, 1'b0);
    tick(1); warp_ack = 1'b1;
    expect_ev(1, 2'd1, 1'b0, 8'h7B, 1'b1, 1'b0);
    tick(1); warp_ack = 1'b0;
    tick(5);
    #2 rst_n = 1'b0;
    #1 check_now("async_reset", outs, 13'h0);
    expect_ev(1, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    check_now("post_reset_idle", outs, 13'h0);
    LocX = 8'h40; tick(2);
    LocX = 8'h7C; expect_ev(1, 2'd0, 1'b1, 8'h02, 1'b1, 1'b0);
    tick(1); warp_ack = 1'b1;
    expect_ev(1, 2'd1, 1'b0, 8'h02, 1'b1, 1'b0);
    tick(1); warp_ack = 1'b0;
    tick(2);

    total++;
    if (exp_q.size() != 0)
      $display("FAIL pending_events actual=%0d required=0", exp_q.size());
    else
      passed++;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
